// File: rtl/pakin_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pakin_pkg
//  Purpose : Shared constants, channel FSM state encoding and helper
//            function for the pakin packet source stage.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pakin_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 4;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_PACKET_SIZE  = 2*NS_ADDRESS_SIZE + NS_DATA_SIZE + NS_REDUN_SIZE;
  localparam int NS_PACKOUT_FSZ  = 2;
  localparam int NS_RED_SEED     = 5;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'h20,
    ST_REQ   = 8'h21,
    ST_ACKLO = 8'h22
  } pakin_state_t;

  function automatic int ns_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pakin_ns_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : pakin_ns_fifo
//  Purpose : 2^FSZ-entry FIFO with FSZ+1-bit pointers; head is the stored
//            entry at the read pointer.
//  Ports   : i_clk/i_rst   clock, asynchronous active-high reset
//            i_push/i_wdata write request and data (ignored when full)
//            i_pop         advance read pointer (ignored when empty)
//            o_head        entry at read pointer
//            o_full/o_empty/o_cnt  status and occupancy 0..2^FSZ
//  Rev     : 1.0  initial release
// ============================================================================
module pakin_ns_fifo #(
  parameter int WID = 20,
  parameter int FSZ = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  logic [WID-1:0] i_wdata,
  input  logic           i_pop,
  output logic [WID-1:0] o_head,
  output logic           o_full,
  output logic           o_empty,
  output logic [FSZ:0]   o_cnt
);

  localparam int         c_DEPTH = 1 << FSZ;
  localparam logic [FSZ:0] c_ONE = {{FSZ{1'b0}}, 1'b1};

  logic [WID-1:0] r_mem [c_DEPTH];
  logic [FSZ:0]   r_wr;
  logic [FSZ:0]   r_rd;
  logic           w_wen;
  logic           w_ren;

  // Extra pointer MSB distinguishes full (laps differ) from empty (identical).
  assign o_full  = (r_wr[FSZ] != r_rd[FSZ]) && (r_wr[FSZ-1:0] == r_rd[FSZ-1:0]);
  assign o_empty = (r_wr == r_rd);
  assign o_cnt   = r_wr - r_rd;
  assign w_wen   = i_push && !o_full;
  assign w_ren   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd[FSZ-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wen) r_wr <= r_wr + c_ONE;
      if (w_ren) r_rd <= r_rd + c_ONE;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_wen) r_mem[r_wr[FSZ-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/pakin.sv
`default_nettype none
// ============================================================================
//  Module  : pakin
//  Purpose : Packet source stage. Buffers {src,dst,dat} words, appends the
//            redundancy field and sends each packet over a 4-phase req/ack
//            channel; flags handshake violations on a sticky error.
//  Ports   : i_clk, i_rst            clock, asynchronous active-high reset
//            inp_vld/inp_rdy         input word handshake (rdy = !full)
//            inp_src/inp_dst/inp_dat input word fields
//            snd0_req/snd0_ack       channel handshake
//            snd0_data               packet {src,dst,dat,red}
//            fifo_cnt                FIFO occupancy
//            has_err                 sticky protocol error
//  Rev     : 1.0  initial release
// ============================================================================
module pakin
  import pakin_pkg::*;
#(
  parameter int ASZ      = NS_ADDRESS_SIZE,
  parameter int DSZ      = NS_DATA_SIZE,
  parameter int RSZ      = NS_REDUN_SIZE,
  parameter int PSZ      = 2*ASZ + DSZ + RSZ,
  parameter int FSZ      = NS_PACKOUT_FSZ,
  parameter int RED_SEED = NS_RED_SEED
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           inp_vld,
  output logic           inp_rdy,
  input  logic [ASZ-1:0] inp_src,
  input  logic [ASZ-1:0] inp_dst,
  input  logic [DSZ-1:0] inp_dat,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic [PSZ-1:0] snd0_data,
  output logic [FSZ:0]   fifo_cnt,
  output logic           has_err
);

  localparam int c_SUM_W = ns_max(ASZ, DSZ) + 2;

  logic [c_SUM_W-1:0] w_sum;
  logic [RSZ-1:0]     w_red;
  logic [PSZ-1:0]     w_pkt;
  logic [PSZ-1:0]     w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  pakin_state_t       r_state;
  pakin_state_t       w_state_nxt;
  logic               r_req;
  logic               w_req_nxt;
  logic [PSZ-1:0]     r_data;
  logic [PSZ-1:0]     w_data_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_ack_q;

  // Redundancy computed at push time so the FIFO stores complete packets.
  assign w_sum  = c_SUM_W'(inp_src) + c_SUM_W'(inp_dst) + c_SUM_W'(inp_dat)
                + c_SUM_W'(RED_SEED);
  assign w_red  = RSZ'(w_sum);
  assign w_pkt  = {inp_src, inp_dst, inp_dat, w_red};
  assign w_push = inp_vld && !w_full;

  pakin_ns_fifo #(
    .WID (PSZ),
    .FSZ (FSZ)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_pkt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (fifo_cnt)
  );

  assign inp_rdy   = !w_full;
  assign snd0_req  = r_req;
  assign snd0_data = r_data;
  assign has_err   = r_err;

  // r_ack_q resets high so an ack still asserted when reset releases is
  // treated as stale (wait for it to drop) rather than as a fresh rise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_req   <= NS_OFF;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_ack_q <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
      r_ack_q <= snd0_ack;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !snd0_ack) begin
          w_data_nxt  = w_head;
          w_req_nxt   = NS_ON;
          w_state_nxt = ST_REQ;
        end
        // Unsolicited ack: rising while no request is outstanding.
        if (snd0_ack && !r_ack_q && !r_req) w_err_nxt = 1'b1;
      end
      ST_REQ: begin
        if (snd0_ack) begin
          w_req_nxt   = NS_OFF;
          w_pop       = 1'b1;
          w_state_nxt = ST_ACKLO;
        end else if (r_ack_q) begin
          // Ack dropped before it was ever accepted high.
          w_err_nxt = 1'b1;
        end
      end
      ST_ACKLO: begin
        if (!snd0_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pakin.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pakin
//  Purpose : Scoreboard bench for pakin: a driver queues expected packets,
//            a pakout-like responder answers requests, a monitor compares.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pakin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        rdy;
  logic [5:0]  src = '0;
  logic [5:0]  dst = '0;
  logic [3:0]  dat = '0;
  logic        req;
  logic        ack = 1'b0;
  logic [19:0] data;
  logic [2:0]  cnt;
  logic        err;

  pakin dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .inp_vld   (vld),
    .inp_rdy   (rdy),
    .inp_src   (src),
    .inp_dst   (dst),
    .inp_dat   (dat),
    .snd0_req  (req),
    .snd0_ack  (ack),
    .snd0_data (data),
    .fifo_cnt  (cnt),
    .has_err   (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n_pop   = 0;
  int          n_rx    = 0;
  logic [19:0] exp_q[$];
  bit          mon_on   = 1'b0;
  bit          err_chk  = 1'b0;
  bit          auto_ack = 1'b0;
  logic        prev_req = 1'b0;

  function automatic logic [19:0] ref_pkt(input logic [5:0] s, input logic [5:0] d,
                                          input logic [3:0] t);
    int r;
    r = (int'(s) + int'(d) + int'(t) + 5) % 16;
    return {s, d, t, 4'(r)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Present one word for one clock; optionally raise ack in the same window.
  task automatic drive(input logic [5:0] s, input logic [5:0] d, input logic [3:0] t,
                       input bit ack_too, output bit took);
    @(negedge clk); #1;
    src = s; dst = d; dat = t; vld = 1'b1;
    if (ack_too) ack = 1'b1;
    took = rdy;
    @(posedge clk); #1;
    vld = 1'b0;
    if (took) begin
      exp_q.push_back(ref_pkt(s, d, t));
      n_acc++;
    end
  endtask

  task automatic push_retry(input logic [5:0] s, input logic [5:0] d, input logic [3:0] t);
    bit took;
    int k;
    k = 0;
    took = 1'b0;
    while (!took && k < 50) begin
      drive(s, d, t, 1'b0, took);
      k++;
    end
    if (!took) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: word never accepted");
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cnt != 3'd0 || req || ack) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s: drain timeout, pending %0d expected 0", name, exp_q.size());
    end
  endtask

  // pakout-like responder: random 0..n cycle delay on each handshake phase.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (auto_ack) begin
        if (req && !ack && ($urandom_range(0, 1) == 0)) ack = 1'b1;
        else if (!req && ack && ($urandom_range(0, 1) == 0)) ack = 1'b0;
      end
    end
  end

  // Monitor: compares each newly raised packet against the scoreboard.
  initial begin
    logic [19:0] exp_pkt;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (prev_req && !req) n_pop++;
        if (req && !prev_req) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL pkt_unexpected: got %05h expected none", data);
          end else begin
            exp_pkt = exp_q.pop_front();
            check("pkt_data", 32'(data), 32'(exp_pkt));
          end
          n_rx++;
        end
        check("fifo_cnt", 32'(cnt), 32'(n_acc - n_pop));
        check("inp_rdy", 32'(rdy), 32'((n_acc - n_pop) < 4));
        if (err_chk) check("has_err_clear", 32'(err), 32'(0));
      end
      prev_req = req;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit took;
    int rx0;
    int k;

    // Reset state
    @(negedge clk);
    check("rst_req", 32'(req), 32'(0));
    check("rst_data", 32'(data), 32'(0));
    check("rst_cnt", 32'(cnt), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rdy", 32'(rdy), 32'(1));
    #1 rst = 1'b0;
    mon_on = 1'b1; err_chk = 1'b1;

    // Test 1: single packet {3,2,5}
    drive(6'd3, 6'd2, 4'd5, 1'b0, took);
    check("t1_took", 32'(took), 32'(1));
    @(negedge clk);
    check("t1_req_lat1", 32'(req), 32'(0));
    check("t1_cnt1", 32'(cnt), 32'(1));
    @(negedge clk);
    check("t1_req_lat2", 32'(req), 32'(1));
    check("t1_data", 32'(data), 32'h0C25F);
    #1 ack = 1'b1;
    @(negedge clk);
    check("t1_req_drop", 32'(req), 32'(0));
    check("t1_cnt0", 32'(cnt), 32'(0));
    #1 ack = 1'b0;
    repeat (2) @(negedge clk);

    // Test 2: fill with ack held low, 5th word dropped, then drain 4
    rx0 = n_rx;
    for (int i = 0; i < 5; i++) begin
      drive(6'(10 + i), 6'(20 + i), 4'(i), 1'b0, took);
      check("t2_took", 32'(took), 32'(i < 4));
      if (i == 3) begin
        check("t2_rdy_full", 32'(rdy), 32'(0));
        check("t2_cnt_full", 32'(cnt), 32'(4));
      end
    end
    check("t2_cnt_after5", 32'(cnt), 32'(4));
    auto_ack = 1'b1;
    wait_drain("t2_drain");
    check("t2_rx_count", 32'(n_rx - rx0), 32'(4));

    // Test 3: pointer wrap with responsive ack
    rx0 = n_rx;
    for (int i = 0; i < 10; i++) push_retry(6'(i), 6'(i + 1), 4'(i & 15));
    wait_drain("t3_drain");
    check("t3_rx_count", 32'(n_rx - rx0), 32'(10));
    check("t3_err", 32'(err), 32'(0));

    // Randomized stream with idle gaps
    rx0 = n_rx;
    for (int i = 0; i < 40; i++) begin
      push_retry(6'($urandom), 6'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("rand_drain");
    check("rand_rx_count", 32'(n_rx - rx0), 32'(40));

    // Test 4: push and pop on the same edge at fifo_cnt=2
    auto_ack = 1'b0;
    drive(6'd7, 6'd8, 4'd9, 1'b0, took);
    drive(6'd11, 6'd12, 4'd13, 1'b0, took);
    k = 0;
    while (!req && k < 10) begin @(negedge clk); k++; end
    check("t4_req_up", 32'(req), 32'(1));
    check("t4_cnt_pre", 32'(cnt), 32'(2));
    drive(6'd14, 6'd15, 4'd1, 1'b1, took);
    check("t4_took", 32'(took), 32'(1));
    check("t4_cnt_same", 32'(cnt), 32'(2));
    auto_ack = 1'b1;
    wait_drain("t4_drain");

    // Test 5: unsolicited ack with empty FIFO
    auto_ack = 1'b0;
    repeat (3) @(negedge clk);
    err_chk = 1'b0;
    #1 ack = 1'b1;
    @(negedge clk);
    check("t5_err_set", 32'(err), 32'(1));
    #1 ack = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_err_sticky", 32'(err), 32'(1));

    // Test 6: reset while in ST_REQ with 3 entries
    for (int i = 0; i < 3; i++) drive(6'(30 + i), 6'(40 + i), 4'(i), 1'b0, took);
    k = 0;
    while (!req && k < 10) begin @(negedge clk); k++; end
    check("t6_req_up", 32'(req), 32'(1));
    check("t6_cnt3", 32'(cnt), 32'(3));
    @(negedge clk); #1;
    mon_on = 1'b0;
    ack = 1'b1;
    rst = 1'b1;
    #1;
    check("t6_req_async", 32'(req), 32'(0));
    check("t6_cnt", 32'(cnt), 32'(0));
    check("t6_err", 32'(err), 32'(0));
    check("t6_rdy", 32'(rdy), 32'(1));
    exp_q.delete();
    n_acc = 0; n_pop = 0;
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1; err_chk = 1'b1;
    drive(6'd5, 6'd6, 4'd7, 1'b0, took);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_req_ack_hi", 32'(req), 32'(0));
    end
    #1 ack = 1'b0;
    k = 0;
    while (!req && k < 6) begin @(negedge clk); k++; end
    check("t6_req_after_acklo", 32'(req), 32'(1));
    auto_ack = 1'b1;
    wait_drain("t6_drain");
    check("t6_err_end", 32'(err), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
